// File: rtl/crc16_tx_sequencer.sv
// rtl/crc16_tx_sequencer.sv - USB DATA packet serializer: PID, payload bytes LSB-first, inverted CRC16
module crc16_tx_sequencer #(
    parameter int MAX_BYTES = 64,
    parameter int LEN_W     = 7,
    parameter int STALL_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       pid,
    input  logic [LEN_W-1:0] payload_len,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    input  logic             bit_ready,
    output logic             bit_valid,
    output logic             bit_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int SC_W = $clog2(STALL_MAX + 1);
    localparam logic [LEN_W-1:0] MAX_LEN    = LEN_W'(MAX_BYTES);
    localparam logic [SC_W-1:0]  STALL_LAST = SC_W'(STALL_MAX - 1);

    typedef enum logic [2:0] {S_IDLE, S_PID, S_FETCH, S_DATA, S_CRC} state_t;

    state_t           state, state_nx;
    logic [7:0]       shreg, shreg_nx;
    logic [3:0]       bit_cnt, bit_cnt_nx;
    logic [LEN_W-1:0] len_cnt, len_nx;
    logic [SC_W-1:0]  stall_cnt, stall_nx;
    logic [15:0]      crc, crc_nx;
    logic             done_nx, err_nx;
    logic             bit_xfer, byte_xfer, fb;

    assign bit_valid  = (state == S_PID) || (state == S_DATA) || (state == S_CRC);
    assign byte_ready = (state == S_FETCH);
    assign busy       = (state != S_IDLE);
    assign bit_xfer   = bit_valid && bit_ready;
    assign byte_xfer  = byte_valid && byte_ready;
    assign fb         = shreg[0] ^ crc[15];

    // CRC bits go out inverted, MSB first, indexed so the register itself stays frozen
    always_comb begin
        bit_out = 1'b0;
        case (state)
            S_PID, S_DATA: bit_out = shreg[0];
            S_CRC:         bit_out = ~crc[4'd15 - bit_cnt];
            default:       bit_out = 1'b0;
        endcase
    end

    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_cnt_nx = bit_cnt;
        len_nx     = len_cnt;
        stall_nx   = stall_cnt;
        crc_nx     = crc;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (payload_len > MAX_LEN) begin
                        err_nx = 1'b1;
                    end else begin
                        state_nx   = S_PID;
                        shreg_nx   = pid;
                        len_nx     = payload_len;
                        crc_nx     = 16'hFFFF;
                        bit_cnt_nx = '0;
                        stall_nx   = '0;
                    end
                end
            end
            S_PID: begin
                if (bit_xfer) begin
                    shreg_nx = {1'b0, shreg[7:1]};
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_nx = '0;
                        state_nx   = (len_cnt != '0) ? S_FETCH : S_CRC;
                    end else begin
                        bit_cnt_nx = bit_cnt + 4'd1;
                    end
                end
            end
            S_FETCH: begin
                if (byte_xfer) begin
                    shreg_nx = byte_data;
                    stall_nx = '0;
                    state_nx = S_DATA;
                end else if (stall_cnt == STALL_LAST) begin
                    stall_nx = '0;
                    err_nx   = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    stall_nx = stall_cnt + SC_W'(1);
                end
            end
            S_DATA: begin
                if (bit_xfer) begin
                    crc_nx   = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
                    shreg_nx = {1'b0, shreg[7:1]};
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_nx = '0;
                        len_nx     = len_cnt - LEN_W'(1);
                        state_nx   = (len_cnt != LEN_W'(1)) ? S_FETCH : S_CRC;
                    end else begin
                        bit_cnt_nx = bit_cnt + 4'd1;
                    end
                end
            end
            S_CRC: begin
                if (bit_xfer) begin
                    if (bit_cnt == 4'd15) begin
                        bit_cnt_nx = '0;
                        done_nx    = 1'b1;
                        state_nx   = S_IDLE;
                    end else begin
                        bit_cnt_nx = bit_cnt + 4'd1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            len_cnt   <= '0;
            stall_cnt <= '0;
            crc       <= 16'hFFFF;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            shreg     <= shreg_nx;
            bit_cnt   <= bit_cnt_nx;
            len_cnt   <= len_nx;
            stall_cnt <= stall_nx;
            crc       <= crc_nx;
            done      <= done_nx;
            err       <= err_nx;
        end
    end

endmodule

// File: tb/tb_crc16_tx_sequencer.sv
// tb/tb_crc16_tx_sequencer.sv - scoreboard bench for crc16_tx_sequencer
module tb_crc16_tx_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, byte_valid, bit_ready;
    logic [7:0] pid, byte_data;
    logic [6:0] payload_len;
    logic       byte_ready, bit_valid, bit_out, busy, done, err;

    crc16_tx_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .pid(pid), .payload_len(payload_len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .bit_ready(bit_ready), .bit_valid(bit_valid), .bit_out(bit_out),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic b; logic feed; } ebit_t;

    ebit_t      exp_q[$];
    logic [7:0] src_q[$];
    logic [7:0] pl [0:63];
    int         n_pass = 0, n_total = 0;
    int         n_done = 0, n_err = 0, n_bytes = 0, cyc = 0;
    int         first_cyc = 0, done_cyc = 0;
    bit         first_seen = 0, prev_hold = 0, prev_bit = 0, byte_taken = 0;
    bit         src_en = 1, rnd_ready = 0;
    logic [15:0] resid = 16'hFFFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] lfsr(input logic [15:0] c, input logic d);
        logic f;
        f = d ^ c[15];
        return {c[14:0], 1'b0} ^ (f ? 16'h8005 : 16'h0000);
    endfunction

    // Monitor: pops the scoreboard on every bit transfer and tracks pulses
    always @(negedge clk) begin
        ebit_t e;
        cyc++;
        if (!rst) begin
            if (prev_hold) chk("bit_hold", 32'({bit_valid, bit_out}), 32'({1'b1, prev_bit}));
            if (bit_valid && bit_ready) begin
                if (!first_seen) begin first_seen = 1; first_cyc = cyc; end
                chk("bit_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("bit_out", 32'(bit_out), 32'(e.b));
                    if (e.feed) resid = lfsr(resid, bit_out);
                end
            end
            if (byte_valid && byte_ready) begin n_bytes++; byte_taken = 1; end
            if (done) begin n_done++; done_cyc = cyc; chk("busy_at_done", 32'(busy), 32'd0); end
            if (err) n_err++;
            prev_hold = bit_valid && !bit_ready;
            prev_bit  = bit_out;
        end else begin
            prev_hold = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (byte_taken) begin void'(src_q.pop_front()); byte_taken = 0; end
        byte_valid = src_en && (src_q.size() != 0);
        byte_data  = (src_q.size() != 0) ? src_q[0] : 8'h00;
        bit_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic pulse_start(input logic [7:0] p, input int len);
        @(posedge clk); #1;
        start = 1; pid = p; payload_len = 7'(len);
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic build(input logic [7:0] p, input int len, input bit with_crc);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < 8; i++) exp_q.push_back('{b: p[i], feed: 1'b0});
        for (int k = 0; k < len; k++) begin
            src_q.push_back(pl[k]);
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back('{b: pl[k][i], feed: 1'b1});
                c = lfsr(c, pl[k][i]);
            end
        end
        if (with_crc)
            for (int i = 15; i >= 0; i--) exp_q.push_back('{b: ~c[i], feed: 1'b1});
        resid = 16'hFFFF;
        first_seen = 0;
    endtask

    task automatic wait_end(input int d0, input int e0);
        for (int i = 0; i < 3000 && n_done == d0 && n_err == e0; i++) @(posedge clk);
        chk("end_timeout", 32'(n_done != d0 || n_err != e0), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_packet(input logic [7:0] p, input int len);
        int d0, e0, b0;
        d0 = n_done; e0 = n_err; b0 = n_bytes;
        build(p, len, 1'b1);
        pulse_start(p, len);
        wait_end(d0, e0);
        chk("done_count", 32'(n_done - d0), 32'd1);
        chk("no_err", 32'(n_err - e0), 32'd0);
        chk("bits_left", 32'(exp_q.size()), 32'd0);
        chk("residual", 32'(resid), 32'h800D);
        chk("byte_count", 32'(n_bytes - b0), 32'(len));
    endtask

    initial begin
        int d0, e0;
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int d0, e0, b0;
        rst = 1; start = 0; pid = 0; payload_len = 0;
        byte_valid = 0; byte_data = 0; bit_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'({bit_valid, bit_out, byte_ready, busy, done, err}), 32'd0);
        @(posedge clk); #1 rst = 0;

        // zero length: C3 then sixteen zeros, done 24 cycles after first bit
        run_packet(8'hC3, 0);
        chk("zero_len_latency", 32'(done_cyc - first_cyc), 32'd24);

        pl[0] = 8'h00; pl[1] = 8'h01; pl[2] = 8'h02; pl[3] = 8'h03;
        run_packet(8'h4B, 4);

        pl[0] = 8'hA5; pl[1] = 8'h3C; pl[2] = 8'hF0;
        rnd_ready = 1;
        run_packet(8'h87, 3);
        rnd_ready = 0;

        d0 = n_done; e0 = n_err;
        pulse_start(8'hC3, 65);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("len_err_busy", 32'(busy), 32'd0);
        end
        chk("len_err_pulse", 32'(n_err - e0), 32'd1);
        chk("len_err_no_done", 32'(n_done - d0), 32'd0);

        for (int k = 0; k < 64; k++) pl[k] = 8'(k * 37 + 1);
        run_packet(8'hE1, 64);

        // stall: PID goes out, then no bytes arrive
        src_en = 0;
        d0 = n_done; e0 = n_err; b0 = n_bytes;
        build(8'h69, 0, 1'b0);
        pulse_start(8'h69, 2);
        wait_end(d0, e0);
        chk("stall_err", 32'(n_err - e0), 32'd1);
        chk("stall_no_done", 32'(n_done - d0), 32'd0);
        chk("stall_bits_left", 32'(exp_q.size()), 32'd0);
        chk("stall_busy", 32'(busy), 32'd0);
        src_en = 1;
        pl[0] = 8'h11; pl[1] = 8'h22;
        run_packet(8'h69, 2);

        // reset in the middle of the first payload byte
        pl[0] = 8'h5A; pl[1] = 8'hC6; pl[2] = 8'h0F;
        build(8'h5A, 3, 1'b1);
        pulse_start(8'h5A, 3);
        for (int i = 0; i < 200 && exp_q.size() > 36; i++) @(negedge clk);
        chk("reached_data", 32'(exp_q.size() <= 36), 32'd1);
        d0 = n_done; e0 = n_err;
        @(posedge clk); #1 rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_reset_outputs", 32'({bit_valid, bit_out, byte_ready, busy, done, err}), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        exp_q.delete(); src_q.delete(); byte_taken = 0;
        repeat (5) @(posedge clk);
        chk("reset_no_pulse", 32'((n_done - d0) + (n_err - e0)), 32'd0);
        pl[0] = 8'h9E;
        run_packet(8'hD2, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/crc16_tx_sequencer.md
Name: crc16_tx_sequencer

Overview:
- Sequences one USB DATA packet body onto a serial bit stream: PID byte, N payload bytes, then the 16-bit CRC.
- Pulls payload bytes over a valid/ready byte interface and serializes them LSB-first.
- Runs the CRC16 over payload bits only and appends the inverted remainder.
- Sits between the packet buffer and the bit-stuff/NRZI stage of the Serial Interface Engine transmitter.

Parameters:
- MAX_BYTES, 64, maximum payload length accepted; larger requests are rejected.
- LEN_W, 7, width of payload_len; must satisfy 2^LEN_W > MAX_BYTES.
- STALL_MAX, 16, maximum consecutive cycles spent waiting for a payload byte before the packet is aborted.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to send a packet; sampled only in IDLE.
- pid  in  8  PID byte; captured on an accepted start.
- payload_len  in  LEN_W  number of payload bytes; captured on an accepted start; 0 is legal.
- byte_valid  in  1  a payload byte is available.
- byte_data  in  8  payload byte.
- byte_ready  out  1  sequencer accepts byte_data this cycle.
- bit_ready  in  1  downstream stage accepts a bit this cycle.
- bit_valid  out  1  bit_out is valid.
- bit_out  out  1  serial bit.
- busy  out  1  high from an accepted start until return to IDLE.
- done  out  1  one-cycle pulse after the last CRC bit is transferred.
- err  out  1  one-cycle pulse on abort (length or stall error).

Behaviour:
- Reset: all outputs are 0. State is IDLE. CRC register = 16'hFFFF. Counters = 0. Reset takes priority in every state, including mid-packet, and the packet in flight is dropped with no done or err.
- Bit transfer: a bit moves when bit_valid && bit_ready. bit_out and bit_valid change only after a transfer or on a state change. bit_valid is never withdrawn without a transfer, except by reset.
- Byte transfer: a byte moves when byte_valid && byte_ready. byte_ready = 1 only in state FETCH.
- State IDLE:
  - On start with payload_len > MAX_BYTES: pulse err next cycle, remain IDLE, busy stays 0.
  - On start with a legal length: latch pid and payload_len, set CRC = FFFF, go to PID, busy = 1.
- State PID:
  - Shift out the 8 PID bits LSB-first. The CRC is not updated.
  - After the 8th transfer: go to FETCH if the remaining length > 0, otherwise go to CRC.
- State FETCH:
  - byte_ready = 1 and bit_valid = 0. The stall counter increments each cycle without a byte.
  - On a byte transfer: load the shift register, clear the stall counter, go to DATA.
  - If the stall counter reaches STALL_MAX: pulse err, go to IDLE, busy = 0.
- State DATA:
  - Shift out 8 bits LSB-first.
  - CRC update on each transferred bit d: fb = d ^ crc[15]; crc <= {crc[14:0],1'b0} ^ (fb ? 16'h8005 : 16'h0000).
  - After the 8th transfer, decrement the remaining length; go to FETCH if it is nonzero, else go to CRC.
- State CRC:
  - Transmit ~crc[15] first, down to ~crc[0] (16 transfers). The CRC register freezes during this state.
  - After the 16th transfer: done pulses for 1 cycle, state returns to IDLE, busy = 0.
- Latency and throughput:
  - The first PID bit is valid on the cycle after an accepted start.
  - With bit_ready held at 1, each byte boundary adds exactly 1 FETCH cycle, provided byte_valid is already high.
- start while busy is ignored. A new start is accepted on the cycle after done.
- The counters never wrap: the bit counter is 0..15 and the length counter runs down from payload_len to 0.

Test Plan:
- Zero-length packet, pid=8'hC3, bit_ready=1 -> the stream is C3 LSB-first (1,1,0,0,0,0,1,1) followed by 16 zero bits (~FFFF); done pulses 24 cycles after the first bit; busy falls with done.
- Payload 00 01 02 03, pid=8'h4B -> the 32 payload bits plus 16 CRC bits, fed into an independent LFSR of the same form (init FFFF, no inversion), leave residual 16'h800D; byte_ready pulses exactly 4 times.
- bit_ready toggled pseudo-randomly during a 3-byte packet -> bit sequence is identical to the bit_ready=1 run; bit_out is stable while bit_valid && !bit_ready.
- payload_len = MAX_BYTES+1 -> err pulses once and busy stays 0; payload_len = MAX_BYTES -> done, no err.
- byte_valid held low in FETCH for STALL_MAX cycles -> err pulse, return to IDLE; a following legal start then sends a correct packet.
- rst asserted mid-DATA -> next cycle all outputs are 0 and no done/err; start with pid=8'hD2, len=1 after reset sends a correct packet.
